// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide sequencer for the execute stage.
// Owns HI/LO, computes the result at issue time, holds it in p_hi/p_lo for
// the configured latency, then commits it. Also raises busy and the D-stage
// stall that holds younger MDU instructions until the unit is free.
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        rst,          // asynchronous, active-low
   input  logic        start,
   input  logic        move_to,
   input  logic        move_from,
   input  logic [2:0]  sel,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        d_uses_mdu,
   output logic        busy,
   output logic        stall,
   output logic [31:0] rd_data,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   // Operation encoding carried on sel.
   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5,
      OP_MFHI  = 3'd6,
      OP_MFLO  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } state_e;

   // The counter must hold the larger latency minus one, and is never
   // narrower than 4 bits.
   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = ($clog2(MAX_CYCLES) > 4) ? $clog2(MAX_CYCLES) : 4;
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   op_e              op;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic [31:0]      p_hi_q, p_hi_d;
   logic [31:0]      p_lo_q, p_lo_d;
   logic             divzero_q, divzero_d;

   // Arithmetic results, valid in the issue cycle only.
   logic [63:0] mul_a, mul_b, product;
   logic        op_signed;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag, b_safe;
   logic [31:0] q_mag, r_mag;
   logic [31:0] quotient, remainder;

   assign op = op_e'(sel);

   // Combinational multiply and sign-magnitude divide of the issued operands.
   // NOTE: every variable written in an always_comb gets a value on every path
   // (here, unconditionally); a path that skips one infers a latch.
   always_comb begin
      // sel[0] clear selects the signed flavour for both mult and div.
      op_signed = ~sel[0];

      mul_a   = op_signed ? {{32{src_a[31]}}, src_a} : {32'd0, src_a};
      mul_b   = op_signed ? {{32{src_b[31]}}, src_b} : {32'd0, src_b};
      product = mul_a * mul_b;

      // Divide on magnitudes, then restore signs: quotient truncates toward
      // zero, remainder follows the dividend. 0x80000000 / -1 falls out
      // naturally as 0x80000000 rem 0 because the magnitude is unsigned.
      a_neg  = op_signed & src_a[31];
      b_neg  = op_signed & src_b[31];
      a_mag  = a_neg ? (32'd0 - src_a) : src_a;
      b_mag  = b_neg ? (32'd0 - src_b) : src_b;
      // A zero divisor never commits; substitute 1 to keep the datapath defined.
      b_safe = (src_b == 32'd0) ? 32'd1 : b_mag;
      q_mag  = a_mag / b_safe;
      r_mag  = a_mag % b_safe;

      quotient  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
      remainder = a_neg ? (32'd0 - r_mag) : r_mag;
   end

   // Next-state, counter, pending-result and HI/LO update logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      p_hi_d    = p_hi_q;
      p_lo_d    = p_lo_q;
      divzero_d = divzero_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start && (op == OP_MULT || op == OP_MULTU)) begin
               p_hi_d    = product[63:32];
               p_lo_d    = product[31:0];
               divzero_d = 1'b0;
               cnt_d     = MULT_LOAD;
               state_d   = ST_MUL;
            end else if (start && (op == OP_DIV || op == OP_DIVU)) begin
               p_hi_d    = remainder;
               p_lo_d    = quotient;
               divzero_d = (src_b == 32'd0);
               cnt_d     = DIV_LOAD;
               state_d   = ST_DIV;
            end else if (move_to && op == OP_MTHI) begin
               hi_d = src_a;
            end else if (move_to && op == OP_MTLO) begin
               lo_d = src_a;
            end
         end

         ST_MUL, ST_DIV: begin
            // New issues are ignored here; the stall keeps them out anyway.
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               if (!(state_q == ST_DIV && divzero_q)) begin
                  hi_d = p_hi_q;
                  lo_d = p_lo_q;
               end
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   // NOTE: sequential state uses non-blocking assignment so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         p_hi_q    <= '0;
         p_lo_q    <= '0;
         divzero_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         p_hi_q    <= p_hi_d;
         p_lo_q    <= p_lo_d;
         divzero_q <= divzero_d;
      end
   end

   // mfhi/mflo read port; reads while busy see committed HI/LO.
   always_comb begin
      rd_data = '0;
      if (move_from) begin
         if (op == OP_MFHI) begin
            rd_data = hi_q;
         end else if (op == OP_MFLO) begin
            rd_data = lo_q;
         end
      end
   end

   assign busy   = (state_q != ST_IDLE);
   // start alone raises stall so a D-stage MDU op never slips in behind it.
   assign stall  = d_uses_mdu & (busy | start);
   assign hi_out = hi_q;
   assign lo_out = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed and randomized operations
// compared against a plain-arithmetic reference model of HI/LO.
module tb_mdu_ctrl;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, move_to, move_from, d_uses_mdu;
   logic [2:0]  sel;
   logic [31:0] src_a, src_b;
   logic        busy, stall;
   logic [31:0] rd_data, hi_out, lo_out;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] model_hi = '0;
   logic [31:0] model_lo = '0;

   mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .move_to    (move_to),
      .move_from  (move_from),
      .sel        (sel),
      .src_a      (src_a),
      .src_b      (src_b),
      .d_uses_mdu (d_uses_mdu),
      .busy       (busy),
      .stall      (stall),
      .rd_data    (rd_data),
      .hi_out     (hi_out),
      .lo_out     (lo_out)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: architectural effect of one completed operation.
   function automatic void model_exec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, sq, sr;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         3'd0: begin p = sa * sb; model_hi = p[63:32]; model_lo = p[31:0]; end
         3'd1: begin p = {32'd0, a} * {32'd0, b}; model_hi = p[63:32]; model_lo = p[31:0]; end
         3'd2: if (b != 0) begin
            sq = sa / sb; sr = sa % sb;
            p = sq; model_lo = p[31:0];
            p = sr; model_hi = p[31:0];
         end
         3'd3: if (b != 0) begin model_lo = a / b; model_hi = a % b; end
         3'd4: model_hi = a;
         3'd5: model_lo = a;
         default: ;
      endcase
   endfunction

   // Issue one start at the current (post-negedge) point and measure busy cycles.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int cycles);
      start = 1'b1; sel = op; src_a = a; src_b = b;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      cycles = 0;
      while (busy === 1'b1 && cycles < 200) begin
         cycles++;
         @(negedge clk);
      end
      model_exec(op, a, b);
   endtask

   task automatic do_move(input logic [2:0] op, input logic [31:0] a);
      move_to = 1'b1; sel = op; src_a = a;
      @(posedge clk); @(negedge clk);
      move_to = 1'b0;
      model_exec(op, a, 32'd0);
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 0; move_to = 0; move_from = 0; d_uses_mdu = 0;
      sel = '0; src_a = '0; src_b = '0;
      repeat (3) @(negedge clk);
      n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (stall !== 1'b0)    begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
      n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_rd got %h want 0", rd_data); end
      n_checks++; if (hi_out !== 32'd0)  begin n_fail++; $display("FAIL reset_hi got %h want 0", hi_out); end
      n_checks++; if (lo_out !== 32'd0)  begin n_fail++; $display("FAIL reset_lo got %h want 0", lo_out); end
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL post_reset_busy got %b want 0", busy); end
   endtask

   task automatic test_mult();
      int cyc;
      logic [2:0] op;
      run_op(3'd0, 32'hFFFF_FFFE, 32'd3, cyc);
      n_checks++; if (cyc !== MULT_N)            begin n_fail++; $display("FAIL mult_busy got %0d want %0d", cyc, MULT_N); end
      n_checks++; if (hi_out !== 32'hFFFF_FFFF)  begin n_fail++; $display("FAIL mult_hi got %h want ffffffff", hi_out); end
      n_checks++; if (lo_out !== 32'hFFFF_FFFA)  begin n_fail++; $display("FAIL mult_lo got %h want fffffffa", lo_out); end
      for (int i = 0; i < 6; i++) begin
         op = (i % 2 == 0) ? 3'd0 : 3'd1;
         run_op(op, $urandom, $urandom, cyc);
         n_checks++; if (cyc !== MULT_N)      begin n_fail++; $display("FAIL rmult_busy[%0d] got %0d want %0d", i, cyc, MULT_N); end
         n_checks++; if (hi_out !== model_hi) begin n_fail++; $display("FAIL rmult_hi[%0d] got %h want %h", i, hi_out, model_hi); end
         n_checks++; if (lo_out !== model_lo) begin n_fail++; $display("FAIL rmult_lo[%0d] got %h want %h", i, lo_out, model_lo); end
      end
   endtask

   task automatic test_div();
      int cyc;
      logic [31:0] a, b;
      run_op(3'd2, 32'hFFFF_FFF9, 32'd2, cyc);
      n_checks++; if (cyc !== DIV_N)            begin n_fail++; $display("FAIL div_busy got %0d want %0d", cyc, DIV_N); end
      n_checks++; if (lo_out !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo got %h want fffffffd", lo_out); end
      n_checks++; if (hi_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi got %h want ffffffff", hi_out); end
      run_op(3'd3, 32'd7, 32'd2, cyc);
      n_checks++; if (lo_out !== 32'd3) begin n_fail++; $display("FAIL divu_lo got %h want 3", lo_out); end
      n_checks++; if (hi_out !== 32'd1) begin n_fail++; $display("FAIL divu_hi got %h want 1", hi_out); end
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
      n_checks++; if (lo_out !== 32'h8000_0000) begin n_fail++; $display("FAIL divovf_lo got %h want 80000000", lo_out); end
      n_checks++; if (hi_out !== 32'd0)         begin n_fail++; $display("FAIL divovf_hi got %h want 0", hi_out); end
      for (int i = 0; i < 8; i++) begin
         a = $urandom;
         b = (i % 2 == 0) ? $urandom_range(1, 1000) : $urandom;
         if (i == 5) b = 32'hFFFF_FFF0 | $urandom_range(1, 15);
         if (b == 0) b = 32'd9;
         run_op((i % 3 == 0) ? 3'd3 : 3'd2, a, b, cyc);
         n_checks++; if (cyc !== DIV_N)       begin n_fail++; $display("FAIL rdiv_busy[%0d] got %0d want %0d", i, cyc, DIV_N); end
         n_checks++; if (lo_out !== model_lo) begin n_fail++; $display("FAIL rdiv_lo[%0d] got %h want %h", i, lo_out, model_lo); end
         n_checks++; if (hi_out !== model_hi) begin n_fail++; $display("FAIL rdiv_hi[%0d] got %h want %h", i, hi_out, model_hi); end
      end
   endtask

   task automatic test_divzero();
      int cyc;
      do_move(3'd4, 32'h0000_1234);
      move_from = 1'b1; sel = 3'd6; #1;
      n_checks++; if (rd_data !== 32'h1234) begin n_fail++; $display("FAIL mfhi_after_mthi got %h want 1234", rd_data); end
      move_from = 1'b0;
      do_move(3'd5, 32'h0000_5678);
      run_op(3'd2, 32'd99, 32'd0, cyc);
      n_checks++; if (cyc !== DIV_N)       begin n_fail++; $display("FAIL dz_busy got %0d want %0d", cyc, DIV_N); end
      n_checks++; if (hi_out !== model_hi) begin n_fail++; $display("FAIL dz_hi got %h want %h", hi_out, model_hi); end
      n_checks++; if (lo_out !== model_lo) begin n_fail++; $display("FAIL dz_lo got %h want %h", lo_out, model_lo); end
      move_from = 1'b1; sel = 3'd7; #1;
      n_checks++; if (rd_data !== 32'h5678) begin n_fail++; $display("FAIL dz_mflo got %h want 5678", rd_data); end
      move_from = 1'b0; #1;
      n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL rd_idle got %h want 0", rd_data); end
      @(negedge clk);
   endtask

   task automatic test_stall();
      for (int pass = 0; pass < 2; pass++) begin
         logic want;
         want = (pass == 0);
         d_uses_mdu = want;
         start = 1'b1; sel = 3'd1; src_a = 32'd6; src_b = 32'd7; #1;
         n_checks++; if (stall !== want) begin n_fail++; $display("FAIL stall_start[%0d] got %b want %b", pass, stall, want); end
         @(posedge clk); @(negedge clk);
         start = 1'b0;
         for (int c = 0; c < MULT_N; c++) begin
            n_checks++; if (stall !== want) begin n_fail++; $display("FAIL stall_busy[%0d][%0d] got %b want %b", pass, c, stall, want); end
            @(negedge clk);
         end
         n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_after[%0d] got %b want 0", pass, stall); end
         n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL busy_after[%0d] got %b want 0", pass, busy); end
         model_exec(3'd1, 32'd6, 32'd7);
      end
      d_uses_mdu = 1'b0;
   endtask

   task automatic test_ignored();
      int cyc;
      start = 1'b1; sel = 3'd0; src_a = 32'hFFFF_FF00; src_b = 32'd1000;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (busy === 1'b1 && cyc < 200) begin
         cyc++;
         start = 1'b0; move_to = 1'b0;
         if (cyc == 2) begin start = 1'b1; sel = 3'd1; src_a = 32'hDEAD_BEEF; src_b = 32'h1234_5678; end
         if (cyc == 3) begin move_to = 1'b1; sel = 3'd4; src_a = 32'hCAFE_F00D; end
         @(negedge clk);
      end
      start = 1'b0; move_to = 1'b0;
      model_exec(3'd0, 32'hFFFF_FF00, 32'd1000);
      n_checks++; if (cyc !== MULT_N)      begin n_fail++; $display("FAIL ign_busy got %0d want %0d", cyc, MULT_N); end
      n_checks++; if (hi_out !== model_hi) begin n_fail++; $display("FAIL ign_hi got %h want %h", hi_out, model_hi); end
      n_checks++; if (lo_out !== model_lo) begin n_fail++; $display("FAIL ign_lo got %h want %h", lo_out, model_lo); end
   endtask

   task automatic test_back_to_back();
      int cyc;
      logic [2:0] ops [3] = '{3'd0, 3'd2, 3'd1};
      for (int i = 0; i < 3; i++) begin
         run_op(ops[i], $urandom, $urandom_range(1, 50000), cyc);
         n_checks++; if (cyc !== ((ops[i] == 3'd2) ? DIV_N : MULT_N))
            begin n_fail++; $display("FAIL b2b_busy[%0d] got %0d", i, cyc); end
         n_checks++; if (hi_out !== model_hi) begin n_fail++; $display("FAIL b2b_hi[%0d] got %h want %h", i, hi_out, model_hi); end
         n_checks++; if (lo_out !== model_lo) begin n_fail++; $display("FAIL b2b_lo[%0d] got %h want %h", i, lo_out, model_lo); end
      end
   endtask

   task automatic test_reset_midop();
      int cyc;
      run_op(3'd1, 32'hABCD_0123, 32'h0F0F_0F0F, cyc);
      start = 1'b1; sel = 3'd2; src_a = 32'd100; src_b = 32'd7;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0; #1;
      model_hi = '0; model_lo = '0;
      n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL rmid_busy got %b want 0", busy); end
      n_checks++; if (hi_out !== 32'd0) begin n_fail++; $display("FAIL rmid_hi got %h want 0", hi_out); end
      n_checks++; if (lo_out !== 32'd0) begin n_fail++; $display("FAIL rmid_lo got %h want 0", lo_out); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_idle got %b want 0", busy); end
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
      n_checks++; if (cyc !== MULT_N)            begin n_fail++; $display("FAIL rmid_busy2 got %0d want %0d", cyc, MULT_N); end
      n_checks++; if (hi_out !== 32'hFFFF_FFFE)  begin n_fail++; $display("FAIL rmid_hi2 got %h want fffffffe", hi_out); end
      n_checks++; if (lo_out !== 32'h0000_0001)  begin n_fail++; $display("FAIL rmid_lo2 got %h want 1", lo_out); end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_divzero();
      test_stall();
      test_ignored();
      test_back_to_back();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide controller for the execute stage. It accepts MDU operations issued by the E-stage pipeline register (start, move-to, move-from, operation select, two operands) and sequences the multiply and divide latencies. It owns the HI/LO registers and generates the busy and decode-stall signals that hold younger MDU instructions in D until the unit is free.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  E-stage StartMDU: mult/multu/div/divu issued this cycle
- move_to  in  1  E-stage MoveToMDU: mthi/mtlo this cycle
- move_from  in  1  E-stage MoveFromMDU: mfhi/mflo this cycle
- sel  in  3  op: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo
- src_a  in  32  rs operand (forwarded)
- src_b  in  32  rt operand (forwarded)
- d_uses_mdu  in  1  instruction in D is any MDU op
- busy  out  1  operation in progress
- stall  out  1  stall D/F, insert bubble into E
- rd_data  out  32  mfhi/mflo result for the E-stage write-back mux
- hi_out  out  32  current HI
- lo_out  out  32  current LO

## Operation
- States: IDLE, MUL, DIV. A 4-bit-or-wider down-counter `cnt` and pending result registers `p_hi`/`p_lo` are used.
- IDLE and start=1, sel∈{0,1}: compute the 64-bit product (signed for 0, unsigned for 1) into {p_hi,p_lo}; cnt←MULT_CYCLES−1; go to MUL.
- IDLE and start=1, sel∈{2,3}: p_lo←quotient, p_hi←remainder (signed: quotient truncates toward zero, remainder takes the dividend's sign; unsigned for 3); cnt←DIV_CYCLES−1; go to DIV.
- Divisor 0: the state still goes to DIV for the full latency, but HI/LO are left unchanged at completion (a divzero flag is latched at start).
- Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- MUL/DIV: cnt>0 → cnt−1. cnt==0 → write HI←p_hi, LO←p_lo (unless divzero), go to IDLE.
- IDLE and move_to=1: sel 4 → HI←src_a; sel 5 → LO←src_a.
- start, move_to, or any start with sel∉{0..3} while in MUL/DIV is ignored. The stall signal prevents this case, and the block defines it as a no-op.
- rd_data combinational: move_from & sel==6 → HI; move_from & sel==7 → LO; otherwise 0. Reads while busy return the old HI/LO, because stall prevents this case.
- busy = (state≠IDLE).
- stall = d_uses_mdu & (busy | start).

## Timing
- Reset (rst low, asynchronous) sets the following; the block leaves reset on the first clk edge with rst high:
  - state IDLE, cnt 0
  - HI, LO, p_hi, p_lo = 0, divzero 0
  - busy 0, stall 0 (when d_uses_mdu=0), rd_data 0
- Reset during MUL/DIV aborts the operation. HI/LO become 0 and the pending result is discarded.
- start sampled at edge T.
  - busy is high from T through T+N, i.e. exactly N cycles, where N is MULT_CYCLES or DIV_CYCLES.
  - HI/LO take the new value at edge T+N, and busy falls at the same edge.
- stall is combinationally high in the start cycle itself (before T), because start alone is enough to raise it.
- Back-to-back: a start in the first cycle after busy falls is accepted, with no dead cycle.
- mthi/mtlo take effect at the next edge. An mfhi in the following cycle sees the new value.

## Test plan
- Signed mult: src_a=0xFFFFFFFE (−2), src_b=3, start sel=0 → busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- Signed div: src_a=0xFFFFFFF9 (−7), src_b=2, sel=2 → busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Repeat with divu 7/2 → LO=3, HI=1.
- Divide by zero: preload HI=0x1234, LO=0x5678 via mthi/mtlo, then div by 0 → busy 10 cycles; HI/LO unchanged; mflo rd_data=0x5678.
- Stall: d_uses_mdu=1 held during the start cycle and all busy cycles → stall high in the start cycle through the last busy cycle, low the cycle after. With d_uses_mdu=0, stall stays 0.
- Ignored issue: start with sel=1 while busy from a mult → result is that of the first mult only; busy ends on schedule.
- Reset mid-op: assert rst low 3 cycles into a div → busy, HI, LO = 0 immediately. After release the unit is in IDLE, and a new multu 0xFFFFFFFF×0xFFFFFFFF gives HI=0xFFFFFFFE, LO=0x00000001.
